// File: rtl/uart_runner.sv
`timescale 1ns/1ps
// uart_runner: 8N1 UART transceiver with optional internal loopback.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   tx_data_i      byte to transmit
//   tx_valid_i     transmit request (accepted when tx_ready_o is also high)
//   tx_ready_o     transmitter idle
//   txd_o          serial transmit line, idles high
//   rxd_i          serial receive line (asynchronous)
//   loopback_i     1: receiver listens to txd_o instead of rxd_i
//   rx_data_o      last correctly received byte
//   rx_valid_o     one-cycle pulse when rx_data_o updates
//   rx_frame_err_o one-cycle pulse on a bad stop bit
//
// Transmitter states
//   TX_IDLE  | line high, ready for a byte
//   TX_START | driving start bit (0)
//   TX_DATA  | shifting out data bits, LSB first
//   TX_STOP  | driving stop bit (1)
//
// Receiver states
//   RX_IDLE  | waiting for a low on the synchronised line
//   RX_START | timing to the start-bit centre to reject glitches
//   RX_DATA  | sampling 8 data bits at their centres
//   RX_STOP  | sampling the stop bit
//   RX_BREAK | bad stop bit seen, waiting for the line to return high
module uart_runner #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD_RATE    = 115_200,
  // Must be at least 4 so the half-bit timer is non-zero.
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       txd_o,
  input  logic       rxd_i,
  input  logic       loopback_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TMR_ONE   = CW'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_tmr;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_tmr;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic [1:0]    sync;
  logic          rx_bit;

  // Transmitter. txd_o is loaded one bit ahead so the line changes exactly
  // on the timer terminal count; the first bit starts on the accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state   <= TX_IDLE;
      tx_tmr     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      txd_o      <= 1'b1;
      tx_ready_o <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid_i && tx_ready_o) begin
            tx_shift   <= tx_data_i;
            tx_tmr     <= BIT_LAST;
            tx_ready_o <= 1'b0;
            txd_o      <= 1'b0;
            tx_state   <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tmr == '0) begin
            tx_tmr   <= BIT_LAST;
            tx_idx   <= '0;
            txd_o    <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_tmr <= tx_tmr - TMR_ONE;
          end
        end
        TX_DATA: begin
          if (tx_tmr == '0) begin
            tx_tmr <= BIT_LAST;
            if (tx_idx == 3'd7) begin
              txd_o    <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd_o    <= tx_shift[1];
            end
          end else begin
            tx_tmr <= tx_tmr - TMR_ONE;
          end
        end
        TX_STOP: begin
          if (tx_tmr == '0) begin
            tx_ready_o <= 1'b1;
            tx_state   <= TX_IDLE;
          end else begin
            tx_tmr <= tx_tmr - TMR_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser; resets to the idle line level so no false start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync <= 2'b11;
    else         sync <= {sync[0], loopback_i ? txd_o : rxd_i};
  end

  assign rx_bit = sync[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state       <= RX_IDLE;
      rx_tmr         <= '0;
      rx_idx         <= '0;
      rx_shift       <= '0;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
    end else begin
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_bit) begin
            rx_tmr   <= HALF_LAST;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tmr == '0) begin
            if (rx_bit) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_tmr   <= BIT_LAST;
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_tmr <= rx_tmr - TMR_ONE;
          end
        end
        RX_DATA: begin
          if (rx_tmr == '0) begin
            rx_tmr   <= BIT_LAST;
            rx_shift <= {rx_bit, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_tmr <= rx_tmr - TMR_ONE;
          end
        end
        RX_STOP: begin
          if (rx_tmr == '0) begin
            if (rx_bit) begin
              rx_data_o  <= rx_shift;
              rx_valid_o <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              rx_frame_err_o <= 1'b1;
              rx_state       <= RX_BREAK;
            end
          end else begin
            rx_tmr <= rx_tmr - TMR_ONE;
          end
        end
        RX_BREAK: begin
          if (rx_bit) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_runner.sv
`timescale 1ns/1ps
// tb_uart_runner: directed and randomized stimulus for uart_runner.
// The clock runs at 10 MHz so the 115200-baud line keeps its real-time bit
// length (86 clocks per bit) and a 100 us gap is 1000 clocks.
module tb_uart_runner;

  localparam int CLK_HZ  = 10_000_000;
  localparam int BAUD    = 115_200;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int GAP_CYC = CLK_HZ / 10_000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready_o;
  logic       txd_o;
  logic       rxd;
  logic       loopback;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_frame_err_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         err_pulses  = 0;
  int         wide_pulses = 0;
  logic       prev_valid  = 1'b0;
  logic       prev_err    = 1'b0;
  logic [7:0] last_good;
  logic [7:0] ref_bytes[3];

  always #50 clk = ~clk;

  uart_runner #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready_o),
    .txd_o         (txd_o),
    .rxd_i         (rxd),
    .loopback_i    (loopback),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_frame_err_o(rx_frame_err_o)
  );

  // Receive-side observer, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid_o) got_q.push_back(rx_data_o);
    if (rx_frame_err_o) err_pulses <= err_pulses + 1;
    if ((rx_valid_o && prev_valid) || (rx_frame_err_o && prev_err))
      wide_pulses <= wide_pulses + 1;
    prev_valid <= rx_valid_o;
    prev_err   <= rx_frame_err_o;
  end

  initial begin
    #(100_000 * 100);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare everything received so far against the expected byte list.
  task automatic compare_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // Transmit one byte; optionally check the serial waveform at bit centres
  // and the busy time. A stray request is injected while busy.
  task automatic send(input logic [7:0] b, input bit wave);
    int m;
    bit done;
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    m = 0;
    while (!tx_ready_o && m < 12 * CPB) begin
      @(posedge clk); #1;
      m++;
    end
    check("tx_ready_before_send", tx_ready_o, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("tx_ready_drop", tx_ready_o, 0);
    m = 0;
    done = 1'b0;
    while (!done) begin
      if (m == 3 * CPB) begin
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
      end else begin
        tx_valid = 1'b0;
      end
      if (wave && (m % CPB == CPB / 2) && (m / CPB < 10))
        check($sformatf("tx_bit%0d_of_%02h", m / CPB, b), txd_o, fr[m / CPB]);
      if (tx_ready_o || m > 12 * CPB) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        m++;
      end
    end
    tx_valid = 1'b0;
    if (wave) check("tx_busy_cycles", m, 10 * CPB);
    exp_q.push_back(b);
  endtask

  // Drive one frame onto rxd with the given stop-bit level, then idle high.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    rst_n    = 1'b0;
    rxd      = 1'b1;
    loopback = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    ref_bytes[0] = 8'h55;
    ref_bytes[1] = 8'hAA;
    ref_bytes[2] = 8'hF0;

    // Reset
    cycles(10);
    check("rst_txd", txd_o, 1);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_rx_data", rx_data_o, 8'h00);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_err", rx_frame_err_o, 0);
    rst_n = 1'b1;
    cycles(20);
    check("post_rst_txd", txd_o, 1);
    check("post_rst_tx_ready", tx_ready_o, 1);
    check("post_rst_rx_data", rx_data_o, 8'h00);
    check("post_rst_rx_valid", got_q.size(), 0);

    // Loopback reference traffic with 100 us gaps
    loopback = 1'b1;
    cycles(2);
    for (int i = 0; i < 3; i++) begin
      send(ref_bytes[i], 1'b1);
      cycles(GAP_CYC);
      compare_rx("loop_ref");
    end

    // Random back-to-back loopback bytes
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send(b, 1'b1);
      last_good = b;
    end
    cycles(GAP_CYC);
    compare_rx("loop_rand");
    check("loop_no_frame_err", err_pulses, 0);
    check("loop_last_data", rx_data_o, last_good);

    // External receive
    loopback = 1'b0;
    cycles(10);
    drive_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    cycles(CPB);
    compare_rx("ext_a5");
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      drive_frame(b, 1'b1);
      exp_q.push_back(b);
      last_good = b;
      cycles($urandom_range(CPB, 1));
    end
    cycles(CPB);
    compare_rx("ext_rand");

    // Short low glitch is rejected
    rxd = 1'b0;
    cycles(CPB / 4);
    rxd = 1'b1;
    cycles(12 * CPB);
    check("glitch_no_valid", got_q.size(), 0);
    check("glitch_no_err", err_pulses, 0);

    // Framing error
    drive_frame(8'h3C, 1'b0);
    cycles(CPB);
    check("ferr_pulses", err_pulses, 1);
    check("ferr_no_valid", got_q.size(), 0);
    check("ferr_data_kept", rx_data_o, last_good);
    b = 8'($urandom);
    drive_frame(b, 1'b1);
    exp_q.push_back(b);
    cycles(CPB);
    compare_rx("ferr_recover");

    // Reset in the middle of a transmitted frame
    loopback = 1'b1;
    cycles(5);
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    cycles(4 * CPB);
    check("midrst_busy", tx_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", txd_o, 1);
    check("midrst_tx_ready", tx_ready_o, 1);
    check("midrst_rx_data", rx_data_o, 8'h00);
    cycles(5);
    rst_n = 1'b1;
    cycles(12 * CPB);
    check("midrst_no_partial", got_q.size(), 0);
    check("midrst_no_err", err_pulses, 1);
    send(8'h0F, 1'b1);
    cycles(GAP_CYC);
    compare_rx("midrst_0f");

    check("single_cycle_pulses", wide_pulses, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
